// File: rtl/load_pkg.sv
// Shared definitions for the load alignment unit:
// load op encodings, FSM states and op decode helpers.
package load_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWU = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } state_t;

  // Access size in bytes; the low two funct3 bits
  // encode log2(size).
  function automatic logic [3:0] op_size(
    input logic [2:0] op
  );
    logic [3:0] sz;
    case (op[1:0])
      2'b00:   sz = 4'd1;
      2'b01:   sz = 4'd2;
      2'b10:   sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

  function automatic logic op_illegal(
    input logic [2:0] op,
    input int         xlen
  );
    return (op == OP_ILL) ||
           ((xlen == 32) &&
            ((op == OP_LD) || (op == OP_LWU)));
  endfunction

  // funct3[2] set selects zero extension.
  function automatic logic op_signed(
    input logic [2:0] op
  );
    return ~op[2];
  endfunction

endpackage

// File: rtl/load_extract.sv
// Shift/extract/extend of a (possibly split) load.
// Ports: i_data {hi,lo}, i_offset byte offset,
// i_op funct3, o_result extended XLEN result.
module load_extract
  import load_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] i_data,
  input  logic [OFFW-1:0]   i_offset,
  input  logic [2:0]        i_op,
  output logic [XLEN-1:0]   o_result
);

  logic [2*XLEN-1:0] w_shifted;
  logic [XLEN-1:0]   w_low;
  logic [XLEN-1:0]   w_keep;
  logic [XLEN-1:0]   w_top;
  logic              w_sign;

  always_comb begin
    w_shifted = i_data >> {i_offset, 3'b000};
    w_low     = w_shifted[XLEN-1:0];
    case (op_size(i_op))
      4'd1:    w_keep = XLEN'(64'hFF);
      4'd2:    w_keep = XLEN'(64'hFFFF);
      4'd4:    w_keep = XLEN'(64'hFFFF_FFFF);
      default: w_keep = '1;
    endcase
    // One-hot of the most significant kept bit.
    w_top    = w_keep ^ (w_keep >> 1);
    w_sign   = op_signed(i_op) & (|(w_low & w_top));
    o_result = (w_low & w_keep) |
               (w_sign ? ~w_keep : '0);
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: splits misaligned loads into
// two aligned beats and returns the extended result.
// Ports: ld_* request (valid/ready), mem_* read port
// (req/gnt, rvalid/rdata), rsp_* one-cycle result.
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_op,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int WB   = XLEN / 8;
  localparam int OFFW = $clog2(WB);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_op;
  logic            r_fault;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_hi;

  logic            w_accept;
  logic [3:0]      w_size_in;
  logic            w_misal;
  logic            w_cap_fault;
  logic [4:0]      w_end;
  logic            w_split;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_result;

  assign w_accept  = ld_valid && (r_state == S_IDLE);
  assign w_size_in = op_size(ld_op);
  assign w_misal   = |(ld_addr[3:0] &
                       (w_size_in - 4'd1));

  assign w_cap_fault =
    op_illegal(ld_op, XLEN) ||
    (!ALLOW_MISALIGNED && w_misal);

  // Split when the access runs past the word end.
  assign w_end   = 5'(r_addr[OFFW-1:0]) +
                   5'(op_size(r_op));
  assign w_split = w_end > 5'(WB);

  assign w_base = {r_addr[XLEN-1:OFFW],
                   {OFFW{1'b0}}};

  load_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .i_data  ({r_hi, r_lo}),
    .i_offset(r_addr[OFFW-1:0]),
    .i_op    (r_op),
    .o_result(w_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ld_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    rsp_valid = 1'b0;
    rsp_fault = 1'b0;
    rsp_data  = '0;
    case (r_state)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          w_next = w_cap_fault ? S_RESP : S_REQ0;
        end
      end
      S_REQ0: begin
        mem_req  = 1'b1;
        mem_addr = w_base;
        if (mem_gnt) begin
          w_next = S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          w_next = w_split ? S_REQ1 : S_RESP;
        end
      end
      S_REQ1: begin
        mem_req  = 1'b1;
        mem_addr = w_base + XLEN'(WB);
        if (mem_gnt) begin
          w_next = S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_fault = r_fault;
        rsp_data  = r_fault ? '0 : w_result;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_op    <= '0;
      r_fault <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= ld_addr;
        r_op    <= ld_op;
        r_fault <= w_cap_fault;
        r_hi    <= '0;
      end
      if ((r_state == S_WAIT0) && mem_rvalid) begin
        r_lo <= mem_rdata;
      end
      if ((r_state == S_WAIT1) && mem_rvalid) begin
        r_hi <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed cases plus
// random loads checked against a byte-level model.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_op;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  logic        n_reset;
  logic        n_ld_valid;
  logic        n_ld_ready;
  logic [31:0] n_ld_addr;
  logic [2:0]  n_ld_op;
  logic        n_mem_req;
  logic        n_mem_gnt;
  logic [31:0] n_mem_addr;
  logic        n_mem_rvalid;
  logic [31:0] n_mem_rdata;
  logic        n_rsp_valid;
  logic [31:0] n_rsp_data;
  logic        n_rsp_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_align_unit #(
    .XLEN(32), .ALLOW_MISALIGNED(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_op(ld_op),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault)
  );

  load_align_unit #(
    .XLEN(32), .ALLOW_MISALIGNED(1'b0)
  ) u_dut_na (
    .clk(clk), .reset(n_reset),
    .ld_valid(n_ld_valid), .ld_ready(n_ld_ready),
    .ld_addr(n_ld_addr), .ld_op(n_ld_op),
    .mem_req(n_mem_req), .mem_gnt(n_mem_gnt),
    .mem_addr(n_mem_addr),
    .mem_rvalid(n_mem_rvalid),
    .mem_rdata(n_mem_rdata),
    .rsp_valid(n_rsp_valid),
    .rsp_data(n_rsp_data),
    .rsp_fault(n_rsp_fault)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference: byte array of both beats, pick
  // size bytes at the offset, then extend.
  function automatic void model(
    input  logic [31:0] a,
    input  logic [2:0]  op,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  bit          allow,
    input  int          g,
    output logic [31:0] d,
    output logic        f,
    output int          nreq,
    output int          lat
  );
    int sz;
    int off;
    logic [7:0]  mem [8];
    logic [63:0] v;
    sz = 1 << op[1:0];
    f = (op == 3'd7) || (op == 3'd3) ||
        (op == 3'd6) ||
        (!allow && ((int'(a[2:0]) % sz) != 0));
    if (f) begin
      d = 0; nreq = 0; lat = 1;
      return;
    end
    off = int'(a[1:0]);
    for (int k = 0; k < 4; k++) begin
      mem[k]     = b0[8*k +: 8];
      mem[k + 4] = b1[8*k +: 8];
    end
    v = 0;
    for (int k = 0; k < sz; k++)
      v = v | (64'(mem[off + k]) << (8 * k));
    if (!op[2] && v[8*sz-1])
      v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    d    = v[31:0];
    nreq = (off + sz > 4) ? 2 : 1;
    lat  = nreq * (g + 2) + 1;
  endfunction

  // Issues one load on u_dut and plays memory with
  // g stall cycles before each grant.
  task automatic run_load(
    input  logic [31:0] a,
    input  logic [2:0]  op,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  int          g,
    output int          nreq,
    output logic [31:0] d,
    output logic        f,
    output int          lat,
    output logic [31:0] ra0,
    output logic [31:0] ra1
  );
    int  wait_g;
    bit  pend;
    nreq = 0; d = '0; f = 1'b0; lat = -1;
    ra0 = '0; ra1 = '0;
    wait_g = g; pend = 0;
    @(negedge clk);
    chk("ld_ready_issue", 64'(ld_ready), 64'd1);
    ld_valid = 1'b1; ld_addr = a; ld_op = op;
    @(negedge clk);
    ld_valid = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (nreq == 1) ? b0 : b1;
        pend = 0;
      end
      if (rsp_valid) begin
        d = rsp_data; f = rsp_fault; lat = cyc;
        break;
      end
      if (mem_req) begin
        if (wait_g == 0) begin
          if (nreq == 0) ra0 = mem_addr;
          else ra1 = mem_addr;
          mem_gnt = 1'b1;
          nreq++;
          pend   = 1;
          wait_g = g;
        end else begin
          wait_g--;
        end
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic run_na(
    input  logic [31:0] a,
    input  logic [2:0]  op,
    output logic [31:0] d,
    output logic        f,
    output bit          sawreq,
    output int          lat
  );
    d = '0; f = 1'b0; sawreq = 0; lat = -1;
    @(negedge clk);
    n_ld_valid = 1'b1; n_ld_addr = a; n_ld_op = op;
    @(negedge clk);
    n_ld_valid = 1'b0;
    for (int cyc = 1; cyc < 8; cyc++) begin
      if (n_mem_req) sawreq = 1;
      if (n_rsp_valid) begin
        d = n_rsp_data; f = n_rsp_fault; lat = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          nreq, lat, e_nreq, e_lat, g;
    logic [31:0] d, ra0, ra1, e_d, a, b0, b1;
    logic        f, e_f;
    logic [2:0]  op;
    bit          saw;

    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0;
    ld_op = '0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_reset = 1'b1; n_ld_valid = 1'b0;
    n_ld_addr = '0; n_ld_op = '0;
    n_mem_gnt = 1'b0; n_mem_rvalid = 1'b0;
    n_mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; n_reset = 1'b0;

    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);

    run_load(32'h1003, 3'b000, 32'h80FF1234, 0, 0,
             nreq, d, f, lat, ra0, ra1);
    chk("lb_data", 64'(d), 64'hFFFFFF80);
    chk("lb_fault", 64'(f), 64'd0);
    chk("lb_lat", 64'(lat), 64'd3);
    chk("lb_addr", 64'(ra0), 64'h1000);
    chk("lb_nreq", 64'(nreq), 64'd1);

    run_load(32'h2002, 3'b101, 32'hBEEF0000, 0, 0,
             nreq, d, f, lat, ra0, ra1);
    chk("lhu_data", 64'(d), 64'h0000BEEF);

    run_load(32'h3001, 3'b010, 32'h44332211,
             32'h88776655, 0,
             nreq, d, f, lat, ra0, ra1);
    chk("lw_split_data", 64'(d), 64'h55443322);
    chk("lw_split_lat", 64'(lat), 64'd5);
    chk("lw_split_nreq", 64'(nreq), 64'd2);
    chk("lw_split_a0", 64'(ra0), 64'h3000);
    chk("lw_split_a1", 64'(ra1), 64'h3004);

    run_load(32'hFFFFFFFE, 3'b010, 32'h11223344,
             32'h55667788, 0,
             nreq, d, f, lat, ra0, ra1);
    chk("wrap_a0", 64'(ra0), 64'hFFFFFFFC);
    chk("wrap_a1", 64'(ra1), 64'h0);
    chk("wrap_data", 64'(d), 64'h77881122);

    run_load(32'h10, 3'b111, 0, 0, 0,
             nreq, d, f, lat, ra0, ra1);
    chk("ill_fault", 64'(f), 64'd1);
    chk("ill_data", 64'(d), 64'd0);
    chk("ill_nreq", 64'(nreq), 64'd0);

    // Stray read data in IDLE must not respond.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray_rsp", 64'(rsp_valid), 64'd0);
    chk("stray_ready", 64'(ld_ready), 64'd1);

    // Reset beats a simultaneous request.
    reset = 1'b1; ld_valid = 1'b1;
    ld_addr = 32'h40; ld_op = 3'b010;
    @(negedge clk);
    reset = 1'b0; ld_valid = 1'b0;
    chk("rstprio_req", 64'(mem_req), 64'd0);
    chk("rstprio_ready", 64'(ld_ready), 64'd1);

    // Reset in WAIT0, late read data ignored.
    ld_valid = 1'b1; ld_addr = 32'h40;
    ld_op = 3'b010;
    @(negedge clk);
    ld_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_ready", 64'(ld_ready), 64'd1);
    chk("rstmid_req", 64'(mem_req), 64'd0);
    saw = 0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) saw = 1;
    end
    chk("rstmid_norsp", 64'(saw), 64'd0);
    chk("rstmid_ready2", 64'(ld_ready), 64'd1);

    for (int it = 0; it < 200; it++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0)
        a = 32'hFFFFFFF8 | 32'($urandom_range(0, 7));
      b0 = $urandom; b1 = $urandom;
      g  = $urandom_range(0, 2);
      model(a, op, b0, b1, 1'b1, g,
            e_d, e_f, e_nreq, e_lat);
      run_load(a, op, b0, b1, g,
               nreq, d, f, lat, ra0, ra1);
      chk("rnd_fault", 64'(f), 64'(e_f));
      chk("rnd_data", 64'(d), 64'(e_d));
      chk("rnd_lat", 64'(lat), 64'(e_lat));
      chk("rnd_nreq", 64'(nreq), 64'(e_nreq));
      if (e_nreq > 0)
        chk("rnd_a0", 64'(ra0), 64'(a & ~32'h3));
      if (e_nreq > 1)
        chk("rnd_a1", 64'(ra1),
            64'(32'((a & ~32'h3) + 32'h4)));
    end

    run_na(32'h0001, 3'b001, d, f, saw, lat);
    chk("na_lh_fault", 64'(f), 64'd1);
    chk("na_lh_data", 64'(d), 64'd0);
    chk("na_lh_noreq", 64'(saw), 64'd0);
    chk("na_lh_lat", 64'(lat), 64'd1);

    run_na(32'h0000, 3'b011, d, f, saw, lat);
    chk("na_ld_fault", 64'(f), 64'd1);
    chk("na_ld_data", 64'(d), 64'd0);
    chk("na_ld_noreq", 64'(saw), 64'd0);

    run_na(32'h0003, 3'b000, d, f, saw, lat);
    chk("na_lb_req", 64'(saw), 64'd1);
    chk("na_lb_norsp", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
    chk("na_lb_addr", 64'(n_mem_addr), 64'h0);
    n_reset = 1'b1;
    @(negedge clk);
    n_reset = 1'b0;
    chk("na_rst_ready", 64'(n_ld_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
